instr_encoder: RTL and testbench

Program-loader encoder for the 16-bit datapath ISA. It accepts field-level instruction descriptions over a valid/ready handshake and packs each one into the 16-bit word layout that the instruction decoder unpacks. It writes the words sequentially into instruction memory through a simple write port. It sits between the test/boot loader and the instruction RAM, ahead of the CPU in the load path.

---
 rtl/instr_encoder_if.sv | 37 +++
 rtl/instr_encoder.sv | 116 +++++++++++
 tb/tb_instr_encoder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Loader-side bundle/handshake and instruction-RAM write bus for instr_encoder.
// A bundle transfers on a rising edge where in_valid && in_ready; in_valid and fields must hold until then.
interface instr_encoder_if #(
   parameter int ADDR_W = 8
);
   logic              start;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        opcode;
   logic [1:0]        op;
   logic [2:0]        rn;
   logic [2:0]        rd;
   logic [1:0]        shift;
   logic [2:0]        rm;
   logic [7:0]        imm8;
   logic [4:0]        imm5;
   logic              last;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_din;
   logic [ADDR_W:0]   count;
   logic              busy;
   logic              done;
   logic              full;
   logic              err;
   logic [1:0]        dbg_state;

   modport master (
      output start, in_valid, opcode, op, rn, rd, shift, rm, imm8, imm5, last,
      input  in_ready, mem_write, mem_addr, mem_din, count, busy, done, full, err, dbg_state
   );

   modport slave (
      input  start, in_valid, opcode, op, rn, rd, shift, rm, imm8, imm5, last,
      output in_ready, mem_write, mem_addr, mem_din, count, busy, done, full, err, dbg_state
   );
endinterface

// File: rtl/instr_encoder.sv
// Packs field bundles into 16-bit instruction words and writes them sequentially to instruction RAM.
// Optional macro ENCODER_ILLEGAL_CHECK_EN: reject opcode 000 with a one-cycle err pulse.
module instr_encoder #(
   parameter int          ADDR_W = 8,
   parameter int unsigned BASE   = 0
) (
   input  logic          clk,
   input  logic          reset,
   instr_encoder_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);

   state_t            r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_full;
   logic              r_mem_write;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [15:0]       r_mem_din;
   logic [15:0]       w_enc;
   logic              w_legal;

   always_comb begin
      w_enc = {bus.opcode, bus.op, bus.rn, bus.rd, bus.shift, bus.rm};
      case (bus.opcode)
         3'b110: begin
            if (bus.op[1]) w_enc = {bus.opcode, bus.op, bus.rn, bus.imm8};
            else           w_enc = {bus.opcode, bus.op, 3'b000, bus.rd, bus.shift, bus.rm};
         end
         3'b001, 3'b010: w_enc = {bus.opcode, bus.op, bus.rn, bus.imm8};
         3'b011, 3'b100: w_enc = {bus.opcode, bus.op, bus.rn, bus.rd, bus.imm5};
         3'b111:         w_enc = {bus.opcode, bus.op, 11'b0};
         default:        w_enc = {bus.opcode, bus.op, bus.rn, bus.rd, bus.shift, bus.rm};
      endcase
   end

`ifdef ENCODER_ILLEGAL_CHECK_EN
   logic r_err;
   assign w_legal = (bus.opcode != 3'b000);
   assign bus.err = r_err;
`else
   assign w_legal = 1'b1;
   assign bus.err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_count     <= '0;
         r_full      <= 1'b0;
         r_mem_write <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_din   <= '0;
`ifdef ENCODER_ILLEGAL_CHECK_EN
         r_err       <= 1'b0;
`endif
      end else begin
         r_mem_write <= 1'b0;
`ifdef ENCODER_ILLEGAL_CHECK_EN
         r_err       <= 1'b0;
`endif
         case (r_state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  r_state <= S_LOAD;
                  r_ptr   <= BASE_ADDR;
                  r_count <= '0;
                  r_full  <= 1'b0;
               end
            end
            S_LOAD: begin
               if (bus.in_valid) begin
                  if (w_legal) begin
                     r_mem_write <= 1'b1;
                     r_mem_addr  <= r_ptr;
                     r_mem_din   <= w_enc;
                     r_count     <= r_count + (ADDR_W+1)'(1);
                     // The top address ends the session; the pointer saturates instead of wrapping.
                     if (r_ptr == LAST_ADDR) begin
                        r_full  <= 1'b1;
                        r_state <= S_DONE;
                     end else begin
                        r_ptr <= r_ptr + ADDR_W'(1);
                     end
                  end
`ifdef ENCODER_ILLEGAL_CHECK_EN
                  else begin
                     r_err <= 1'b1;
                  end
`endif
                  if (bus.last) r_state <= S_DONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == S_LOAD);
   assign bus.busy      = (r_state == S_LOAD);
   assign bus.done      = (r_state == S_DONE);
   assign bus.full      = r_full;
   assign bus.count     = r_count;
   assign bus.mem_write = r_mem_write;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_din   = r_mem_din;
   assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed encodes/boundaries followed by randomized sessions,
// each cycle compared against a field-arithmetic reference model.
module tb_instr_encoder;
   localparam int ADDR_W = 4;
   localparam int BASE   = 0;
   localparam int DEPTH  = 1 << ADDR_W;

   // clock / reset
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   instr_encoder_if #(.ADDR_W(ADDR_W)) bus();
   instr_encoder #(.ADDR_W(ADDR_W), .BASE(BASE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // scoreboard and reference model
   int n_checks = 0;
   int n_bad    = 0;
   logic [ADDR_W+15:0] exp_q[$];
   bit m_load, m_done, m_full, e_write, e_err;
   int m_ptr, m_count;
   logic [ADDR_W-1:0] m_addr;
   logic [15:0]       m_din;

   function automatic logic [15:0] encode(int opc, int op, int rn, int rd, int sh, int rm, int i8, int i5);
      int hi;
      int w;
      hi = opc * 8192 + op * 2048;
      if ((opc == 6 && op >= 2) || opc == 1 || opc == 2) w = hi + rn * 256 + i8;
      else if (opc == 6)                                w = hi + rd * 32 + sh * 8 + rm;
      else if (opc == 3 || opc == 4)                    w = hi + rn * 256 + rd * 32 + i5;
      else if (opc == 7)                                w = hi;
      else                                              w = hi + rn * 256 + rd * 32 + sh * 8 + rm;
      return 16'(w);
   endfunction

   function automatic bit is_legal(int opc);
`ifdef ENCODER_ILLEGAL_CHECK_EN
      return opc != 0;
`else
      return 1'b1;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic drive_idle();
      bus.start = 0; bus.in_valid = 0; bus.opcode = 0; bus.op = 0; bus.rn = 0; bus.rd = 0;
      bus.shift = 0; bus.rm = 0; bus.imm8 = 0; bus.imm5 = 0; bus.last = 0;
   endtask

   task automatic set_bundle(input int opc, input int op, input int rn, input int rd, input int sh,
                             input int rm, input int i8, input int i5, input bit lst);
      bus.in_valid = 1; bus.opcode = 3'(opc); bus.op = 2'(op); bus.rn = 3'(rn); bus.rd = 3'(rd);
      bus.shift = 2'(sh); bus.rm = 3'(rm); bus.imm8 = 8'(i8); bus.imm5 = 5'(i5); bus.last = lst;
   endtask

   // Advance the model over the upcoming edge, clock, then compare every output.
   task automatic step();
      logic [ADDR_W+15:0] ent;
      e_write = 0;
      e_err   = 0;
      if (reset) begin
         m_load = 0; m_done = 0; m_full = 0; m_ptr = 0; m_count = 0;
         m_addr = '0; m_din = '0;
         exp_q.delete();
      end else if (!m_load) begin
         if (bus.start) begin
            m_load = 1; m_done = 0; m_full = 0; m_ptr = BASE; m_count = 0;
         end
      end else if (bus.in_valid) begin
         if (is_legal(int'(bus.opcode))) begin
            exp_q.push_back({ADDR_W'(m_ptr), encode(int'(bus.opcode), int'(bus.op), int'(bus.rn), int'(bus.rd),
                                                   int'(bus.shift), int'(bus.rm), int'(bus.imm8), int'(bus.imm5))});
            e_write = 1;
            m_count++;
            if (m_ptr == DEPTH - 1) begin
               m_full = 1; m_load = 0; m_done = 1;
            end else begin
               m_ptr++;
            end
         end else begin
            e_err = 1;
         end
         if (bus.last) begin
            m_load = 0; m_done = 1;
         end
      end
      @(posedge clk);
      #1;
      check("mem_write", bus.mem_write, e_write);
      if (e_write) begin
         ent    = exp_q.pop_front();
         m_addr = ent[ADDR_W+15:16];
         m_din  = ent[15:0];
      end
      check("mem_addr", bus.mem_addr, m_addr);
      check("mem_din", bus.mem_din, m_din);
      check("count", bus.count, m_count);
      check("in_ready", bus.in_ready, m_load);
      check("busy", bus.busy, m_load);
      check("done", bus.done, m_done);
      check("full", bus.full, m_full);
      check("err", bus.err, e_err);
   endtask

   initial begin
      reset = 1;
      drive_idle();
      step();
      step();
      reset = 0;
      check("rst_count", bus.count, 0);
      check("rst_in_ready", bus.in_ready, 0);

      bus.start = 1; step(); bus.start = 0;
      set_bundle(6, 2, 0, 0, 0, 0, 8'h05, 0, 0); step();
      check("mov_imm_din", bus.mem_din, 16'hD005);
      check("mov_imm_addr", bus.mem_addr, 0);
      set_bundle(5, 0, 1, 2, 1, 0, 0, 0, 0); step();
      check("add_din", bus.mem_din, 16'hA148);
      check("add_addr", bus.mem_addr, 1);
      set_bundle(3, 0, 1, 3, 0, 0, 0, 4, 0); step();
      check("ldr_din", bus.mem_din, 16'h6164);
      set_bundle(1, 0, 1, 0, 0, 0, 8'hFE, 0, 0); step();
      check("branch_din", bus.mem_din, 16'h21FE);
      check("branch_addr", bus.mem_addr, 3);
      set_bundle(6, 0, 5, 3, 0, 2, 8'hAA, 0, 0); step();
      check("mov_reg_din", bus.mem_din, 16'hC062);
      set_bundle(0, 1, 2, 3, 1, 4, 0, 0, 0); step();
`ifdef ENCODER_ILLEGAL_CHECK_EN
      check("illegal_err", bus.err, 1);
      check("illegal_nowrite", bus.mem_write, 0);
      check("illegal_count", bus.count, 5);
`else
      check("op000_din", bus.mem_din, 16'h0A6C);
      check("op000_write", bus.mem_write, 1);
`endif
      set_bundle(7, 0, 7, 7, 3, 7, 8'hFF, 31, 1); step();
      check("halt_din", bus.mem_din, 16'hE000);
      check("halt_done", bus.done, 1);
      check("halt_in_ready", bus.in_ready, 0);
`ifdef ENCODER_ILLEGAL_CHECK_EN
      check("halt_count", bus.count, 6);
`else
      check("halt_count", bus.count, 7);
`endif
      set_bundle(5, 1, 1, 1, 1, 1, 0, 0, 0); step();
      check("done_no_accept", bus.mem_write, 0);
      check("hold_din", bus.mem_din, 16'hE000);

      drive_idle();
      bus.start = 1; step(); bus.start = 0;
      check("restart_count", bus.count, 0);
      set_bundle(2, 3, 4, 0, 0, 0, 8'h12, 0, 1); step();
      check("restart_addr", bus.mem_addr, BASE);

      drive_idle();
      bus.start = 1; step(); bus.start = 0;
      for (int i = 0; i < DEPTH; i++) begin
         set_bundle(5, i % 4, i % 8, (i + 1) % 8, i % 4, (i + 3) % 8, 0, 0, 0);
         step();
      end
      check("full_flag", bus.full, 1);
      check("full_done", bus.done, 1);
      check("full_count", bus.count, DEPTH);
      check("full_last_addr", bus.mem_addr, DEPTH - 1);
      step();

      drive_idle();
      bus.start = 1; step(); bus.start = 0;
      set_bundle(4, 1, 2, 3, 0, 0, 0, 9, 0);
      reset = 1; step(); reset = 0;
      check("rst_mid_write", bus.mem_write, 0);
      check("rst_mid_din", bus.mem_din, 0);
      drive_idle();
      step();

      for (int c = 0; c < 1500; c++) begin
         reset      = ($urandom_range(0, 199) == 0);
         bus.start  = ($urandom_range(0, 7) == 0);
         bus.in_valid = ($urandom_range(0, 2) != 0);
         bus.opcode = 3'($urandom_range(0, 7));
         bus.op     = 2'($urandom_range(0, 3));
         bus.rn     = 3'($urandom_range(0, 7));
         bus.rd     = 3'($urandom_range(0, 7));
         bus.shift  = 2'($urandom_range(0, 3));
         bus.rm     = 3'($urandom_range(0, 7));
         bus.imm8   = 8'($urandom_range(0, 255));
         bus.imm5   = 5'($urandom_range(0, 31));
         bus.last   = ($urandom_range(0, 29) == 0);
         step();
      end
      reset = 0;
      drive_idle();
      step();

      // final report
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end
endmodule
